// File: rtl/radix_2_intt_pe_pipe.sv
// radix_2_intt_pe_pipe: pipelined Gentleman-Sande inverse-NTT butterfly with optional halving
module radix_2_intt_pe_pipe #(
  parameter int N = 17,
  parameter int Q = 65537
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] tf,
  input  logic         half_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] an,
  output logic [N-1:0] bn
);
  localparam logic [N:0] QX = Q[N:0];
  localparam logic [2*N-1:0] QP = {{(N-1){1'b0}}, QX};

  logic           adv;
  logic [N:0]     sum;
  logic [N-1:0]   r;
  logic [N-1:0]   s1_d, s1_q, d1_d, d1_q, tf1_d, tf1_q;
  logic           h1_d, h1_q, v1_d, v1_q;
  logic [2*N-1:0] p2_d, p2_q;
  logic [N-1:0]   s2_d, s2_q;
  logic           h2_d, h2_q, v2_d, v2_q;
  logic [N-1:0]   an_d, an_q, bn_d, bn_q;
  logic           out_valid_d, out_valid_q;

  function automatic logic [N-1:0] half(input logic [N-1:0] x);
    return x[0] ? N'(({1'b0, x} + QX) >> 1) : x >> 1;
  endfunction

  // next-state for all three stages; every stage holds together when the output is blocked
  always_comb begin
    adv         = !out_valid_q | out_ready;
    sum         = {1'b0, a} + {1'b0, b};
    r           = N'(p2_q % QP);
    s1_d        = adv ? N'(sum >= QX ? sum - QX : sum) : s1_q;
    d1_d        = adv ? N'(a >= b ? {1'b0, a} - {1'b0, b} : {1'b0, a} + QX - {1'b0, b}) : d1_q;
    tf1_d       = adv ? tf : tf1_q;
    h1_d        = adv ? half_en : h1_q;
    v1_d        = adv ? in_valid : v1_q;
    p2_d        = adv ? {{N{1'b0}}, d1_q} * {{N{1'b0}}, tf1_q} : p2_q;
    s2_d        = adv ? s1_q : s2_q;
    h2_d        = adv ? h1_q : h2_q;
    v2_d        = adv ? v1_q : v2_q;
    an_d        = adv ? (h2_q ? half(s2_q) : s2_q) : an_q;
    bn_d        = adv ? (h2_q ? half(r) : r) : bn_q;
    out_valid_d = adv ? v2_q : out_valid_q;
  end

  // pipeline registers; reset drops every in-flight token
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      d1_q        <= '0;
      tf1_q       <= '0;
      h1_q        <= 1'b0;
      v1_q        <= 1'b0;
      p2_q        <= '0;
      s2_q        <= '0;
      h2_q        <= 1'b0;
      v2_q        <= 1'b0;
      an_q        <= '0;
      bn_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      d1_q        <= d1_d;
      tf1_q       <= tf1_d;
      h1_q        <= h1_d;
      v1_q        <= v1_d;
      p2_q        <= p2_d;
      s2_q        <= s2_d;
      h2_q        <= h2_d;
      v2_q        <= v2_d;
      an_q        <= an_d;
      bn_q        <= bn_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign an        = an_q;
  assign bn        = bn_q;
endmodule
